// File: rtl/ram_seven_segment_display.sv
// ram_seven_segment_display: 16x4 RAM with combinational read, shown on an 8-digit multiplexed common-anode display
module ram_seven_segment_display #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 4,
  parameter int SCAN_DIV = 1
) (
  input  logic              clk1000,
  input  logic              clr,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic [7:0]        an,
  output logic              dp,
  output logic [6:0]        a2g
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [CW-1:0]     div_q, div_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        an_q, an_d;
  logic [6:0]        a2g_q, a2g_d, seg;
  logic              dp_q;
  logic [DATA_W-1:0] disp;
  logic [3:0]        nib;
  logic              wrap;
  assign out  = mem_q[addr];
  assign disp = wen ? in : out;
  assign an   = an_q;
  assign a2g  = a2g_q;
  assign dp   = dp_q;
  // clr wins over a simultaneous write, so a write on a reset edge is lost
  always_ff @(posedge clk1000) begin
    if (clr) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
    end else if (wen) begin
      mem_q[addr] <= in;
    end
  end
  // divider steps the scan index once per SCAN_DIV clocks; only digits 7 and 3 carry data
  always_comb begin
    wrap  = div_q == CW'(SCAN_DIV - 1);
    div_d = wrap ? '0 : div_q + 1'b1;
    idx_d = wrap ? idx_q + 3'd1 : idx_q;
    nib   = idx_q == 3'd7 ? 4'(addr) : idx_q == 3'd3 ? 4'(disp) : 4'h0;
    an_d  = ~(8'b1 << idx_q);
    a2g_d = seg;
  end
  // active-low hex decode, a2g[6]=a .. a2g[0]=g
  always_comb begin
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  end
  // scan state and registered display outputs, which lag the index and data by one clock
  always_ff @(posedge clk1000) begin
    if (clr) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= 8'hFF;
      a2g_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      a2g_q <= a2g_d;
      dp_q  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ram_seven_segment_display.sv
// tb_ram_seven_segment_display: scoreboard bench against a behavioural model of the RAM and display
module tb_ram_seven_segment_display;
  logic       clk = 0;
  logic       clr = 0, wen = 0;
  logic [3:0] addr = 0, in_d = 0;
  logic [3:0] out;
  logic [7:0] an;
  logic       dp;
  logic [6:0] a2g;
  int checks = 0, errors = 0;
  typedef struct {
    bit         chk_out, chk_reg;
    logic [3:0] out_e;
    logic [7:0] an_e;
    logic [6:0] a2g_e;
    logic       dp_e;
  } exp_t;
  exp_t q[$];
  logic [3:0] mem_m [16];
  bit  known = 0, live = 0;
  int  pos = 0;
  logic [6:0] seg_t [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  ram_seven_segment_display dut (
    .clk1000(clk), .clr(clr), .wen(wen), .addr(addr), .in(in_d),
    .out(out), .an(an), .dp(dp), .a2g(a2g)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // drive one clock's inputs and queue the model's prediction for that clock
  task automatic step(input bit c, input bit w, input logic [3:0] a, input logic [3:0] d);
    exp_t e;
    logic [31:0] word;
    logic [3:0]  disp;
    @(negedge clk);
    clr = c; wen = w; addr = a; in_d = d;
    e.chk_out = known;
    e.out_e   = mem_m[a];
    e.dp_e    = 1'b1;
    disp = w ? d : mem_m[a];
    if (c) begin
      e.chk_reg = 1;
      e.an_e    = 8'hFF;
      e.a2g_e   = 7'h7F;
      foreach (mem_m[i]) mem_m[i] = 4'h0;
      known = 1; live = 1; pos = 0;
    end else begin
      e.chk_reg = live;
      word      = {a, 12'h000, disp, 12'h000};
      e.an_e    = ~(8'd1 << pos);
      e.a2g_e   = seg_t[word[4*pos +: 4]];
      pos       = (pos + 1) % 8;
      if (w) mem_m[a] = d;
    end
    q.push_back(e);
  endtask

  // monitor: read data sampled before the edge, display outputs sampled after it
  initial begin
    exp_t e;
    logic [3:0] o;
    forever begin
      @(negedge clk);
      #2 o = out;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.chk_out) chk("out", {4'h0, o}, {4'h0, e.out_e});
        if (e.chk_reg) begin
          chk("an", an, e.an_e);
          chk("a2g", {1'b0, a2g}, {1'b0, e.a2g_e});
          chk("dp", {7'h0, dp}, {7'h0, e.dp_e});
        end
      end
    end
  end

  initial begin
    step(1, 0, 0, 0);
    for (int a = 0; a < 16; a++) step(0, 0, a[3:0], 0);
    step(0, 1, 1, 1);
    repeat (8) step(0, 0, 1, 0);
    step(0, 1, 0, 4'hF);
    repeat (8) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 5, 3);
    repeat (3) step(0, 1, 5, 4'hA);
    step(0, 1, 5, 3);
    repeat (8) step(0, 0, 5, 0);
    step(1, 1, 2, 5);
    step(0, 0, 2, 0);
    step(0, 1, 0, 7);
    step(0, 1, 1, 9);
    step(0, 0, 3, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(39) == 0, $urandom_range(1), 4'($urandom), 4'($urandom));
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
